// File: rtl/hazard_detection_unit.sv
// Front-end stall/bubble control: load-use bubbles and multi-cycle multiply holds; all outputs combinational.
// Optional perf counters guarded by HAZARD_PERF_CNT_EN; when undefined both perf ports are tied to 0.
module hazard_detection_unit #(
  parameter int MULT_LATENCY = 3,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_uses_rs1,
  input  logic        if_id_uses_rs2,
  input  logic [4:0]  id_ex_rd,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_mult,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mult_start,
  output logic        mult_busy,
  output logic [31:0] perf_load_use_cnt,
  output logic [31:0] perf_mult_stall_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MBUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MULT_LATENCY > 1) ? (MULT_LATENCY - 2) : 0);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  logic             lu_stall;
  logic             ms_stall;
  logic             in_idle;
  logic             in_busy;

  assign in_idle = arst_n && (state_q == IDLE);
  assign in_busy = arst_n && (state_q == MBUSY);

  assign lu_hit = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                   (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

  // A multiply in IDLE always wins over a load-use hit, including mult+mem_read encodings.
  assign lu_stall = in_idle && !id_ex_mult && lu_hit;
  assign ms_stall = (in_idle && id_ex_mult && (MULT_LATENCY > 1)) ||
                    (in_busy && (cnt_q != '0));

  assign pc_write     = !(ms_stall || lu_stall);
  assign if_id_write  = !(ms_stall || lu_stall);
  assign id_ex_write  = !ms_stall;
  assign id_ex_flush  = lu_stall;
  assign ex_mem_flush = ms_stall;
  assign mult_start   = in_idle && id_ex_mult;
  assign mult_busy    = in_busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (id_ex_mult && (MULT_LATENCY > 1)) begin
          state_d = MBUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MBUSY: begin
        // cnt==0 is the release cycle: enables reopen and the product moves to EX/MEM.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q;
  logic [31:0] ms_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lu_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      if (lu_stall) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (ms_stall) ms_cnt_q <= ms_cnt_q + 32'd1;
    end
  end

  assign perf_load_use_cnt   = lu_cnt_q;
  assign perf_mult_stall_cnt = ms_cnt_q;
`else
  assign perf_load_use_cnt   = 32'd0;
  assign perf_mult_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit with MULT_LATENCY=3; control outputs compared as one vector.
module tb_hazard_detection_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // {pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_flush, mult_start, mult_busy}
  localparam logic [6:0] RUN      = 7'b1110000;
  localparam logic [6:0] LU       = 7'b0011000;
  localparam logic [6:0] MS_START = 7'b0000110;
  localparam logic [6:0] MS_HOLD  = 7'b0000101;
  localparam logic [6:0] REL      = 7'b1110001;

  logic        clk;
  logic        arst_n;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
  logic        if_id_uses_rs1, if_id_uses_rs2;
  logic        id_ex_mem_read, id_ex_mult;
  logic        pc_write, if_id_write, id_ex_write;
  logic        id_ex_flush, ex_mem_flush, mult_start, mult_busy;
  logic [31:0] perf_load_use_cnt, perf_mult_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_detection_unit #(.MULT_LATENCY(3), .CNT_W(4)) dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .if_id_rs1           (if_id_rs1),
    .if_id_rs2           (if_id_rs2),
    .if_id_uses_rs1      (if_id_uses_rs1),
    .if_id_uses_rs2      (if_id_uses_rs2),
    .id_ex_rd            (id_ex_rd),
    .id_ex_mem_read      (id_ex_mem_read),
    .id_ex_mult          (id_ex_mult),
    .pc_write            (pc_write),
    .if_id_write         (if_id_write),
    .id_ex_write         (id_ex_write),
    .id_ex_flush         (id_ex_flush),
    .ex_mem_flush        (ex_mem_flush),
    .mult_start          (mult_start),
    .mult_busy           (mult_busy),
    .perf_load_use_cnt   (perf_load_use_cnt),
    .perf_mult_stall_cnt (perf_mult_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, 32'({pc_write, if_id_write, id_ex_write, id_ex_flush,
                  ex_mem_flush, mult_start, mult_busy}), 32'(exp));
  endtask

  task automatic chk_perf(input string tag, input int exp_lu, input int exp_ms);
    chk({tag, "_lu"}, perf_load_use_cnt, 32'(PERF * exp_lu));
    chk({tag, "_ms"}, perf_mult_stall_cnt, 32'(PERF * exp_ms));
  endtask

  // Inputs are driven just after the rising edge; outputs sampled on the falling edge.
  task automatic step(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk_ctl(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_mult = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    arst_n = 1'b0;
    // Hazard-looking inputs during reset must not affect the forced outputs.
    id_ex_mult = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
    if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    #2;
    chk_ctl("rst_ctl", RUN);
    chk_perf("rst_perf", 0, 0);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    arst_n = 1'b1;

    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    step("lu_rs1", LU);
    id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
    step("lu_bubble", RUN);
    chk_perf("lu1", 1, 0);

    id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_rs2 = 5'd9;
    if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b1; if_id_rs1 = 5'd0;
    step("lu_rs2", LU);

    id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_uses_rs1 = 1'b1; if_id_uses_rs2 = 1'b0;
    step("no_stall_x0", RUN);
    id_ex_rd = 5'd7; if_id_rs2 = 5'd7; if_id_rs1 = 5'd3;
    step("no_stall_nouse", RUN);
    id_ex_mem_read = 1'b0; if_id_rs1 = 5'd7;
    step("no_stall_noload", RUN);
    chk_perf("lu2", 2, 0);

    clear_inputs();
    id_ex_mult = 1'b1;
    step("ms_c0", MS_START);
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    step("ms_c1_lu_ign", MS_HOLD);
    step("ms_c2_rel", REL);
    clear_inputs();
    step("ms_after", RUN);
    chk_perf("ms1", 2, 2);

    id_ex_mult = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
    if_id_rs1 = 5'd5; if_id_uses_rs1 = 1'b1;
    step("mslu_c0", MS_START);
    step("mslu_c1", MS_HOLD);
    step("mslu_c2", REL);
    clear_inputs();
    step("mslu_after", RUN);
    chk_perf("mslu", 2, 4);

    do_reset();
    chk_perf("b2b_rst", 0, 0);
    id_ex_mult = 1'b1;
    step("b2b_c0", MS_START);
    step("b2b_c1", MS_HOLD);
    step("b2b_c2", REL);
    step("b2b_c3", MS_START);
    step("b2b_c4", MS_HOLD);
    step("b2b_c5", REL);
    id_ex_mult = 1'b0;
    step("b2b_c6", RUN);
    chk_perf("b2b", 0, 4);

    id_ex_mult = 1'b1;
    step("rmid_c0", MS_START);
    #1;
    chk_ctl("rmid_c1", MS_HOLD);
    arst_n = 1'b0;
    #1;
    chk_ctl("rmid_async", RUN);
    chk_perf("rmid", 0, 0);
    @(posedge clk); #1;
    chk_ctl("rmid_hold", RUN);
    arst_n = 1'b1;
    step("rmid_restart", MS_START);
    step("rmid_r1", MS_HOLD);
    step("rmid_r2", REL);
    id_ex_mult = 1'b0;
    step("rmid_after", RUN);
    chk_perf("rmid_end", 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
